// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and the carry-look-ahead group primitive used by every pipeline slice.
// Group width is carried as an argument so one function serves any BLOCK up to MAX_BLOCK.
package pipelined_cla_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 4;
  localparam int MAX_BLOCK  = 32;

  typedef struct packed {
    logic [MAX_BLOCK-1:0] sum;
    logic                 g;
    logic                 p;
    logic                 msb_cin;
  } group_t;

  // Every bit carry is formed from cin and the group terms below it, not from its neighbour.
  function automatic group_t cla_group(input logic [MAX_BLOCK-1:0] a,
                                       input logic [MAX_BLOCK-1:0] b,
                                       input logic                 cin,
                                       input int                   n);
    group_t r;
    logic   gg;
    logic   pp;
    logic   c;
    r  = '0;
    gg = 1'b0;
    pp = 1'b1;
    c  = cin;
    for (int i = 0; i < MAX_BLOCK; i++) begin
      if (i < n) begin
        c        = gg | (pp & cin);
        r.sum[i] = a[i] ^ b[i] ^ c;
        if (i == n - 1) r.msb_cin = c;
        gg = (a[i] & b[i]) | ((a[i] ^ b[i]) & gg);
        pp = (a[i] ^ b[i]) & pp;
      end
    end
    r.g = gg;
    r.p = pp;
    return r;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_slice.sv
// SLICE_W-bit combinational adder built from BLOCK-bit CLA groups; group carries are
// looked ahead from the slice carry-in. Also reports the carry into the slice MSB.
module pipelined_cla_adder_slice
  import pipelined_cla_adder_pkg::*;
#(
  parameter int SLICE_W = 8,
  parameter int BLOCK   = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               msb_cin
);

  localparam int GROUPS = SLICE_W / BLOCK;

  group_t               gr;
  logic [MAX_BLOCK-1:0] ga;
  logic [MAX_BLOCK-1:0] gb;
  logic                 gg;
  logic                 pp;
  logic                 gcin;
  logic                 unused_group_bits;

  // NOTE: every variable gets a value before the loop so this block can never infer a latch.
  always_comb begin
    sum               = '0;
    msb_cin           = 1'b0;
    gr                = '0;
    ga                = '0;
    gb                = '0;
    gg                = 1'b0;
    pp                = 1'b1;
    gcin              = cin;
    unused_group_bits = 1'b0;
    for (int k = 0; k < GROUPS; k++) begin
      gcin                  = gg | (pp & cin);
      ga                    = '0;
      gb                    = '0;
      ga[BLOCK-1:0]         = a[k*BLOCK +: BLOCK];
      gb[BLOCK-1:0]         = b[k*BLOCK +: BLOCK];
      gr                    = cla_group(ga, gb, gcin, BLOCK);
      sum[k*BLOCK +: BLOCK] = gr.sum[BLOCK-1:0];
      msb_cin               = gr.msb_cin;
      // Lanes above BLOCK are always zero; folding them keeps the record fully consumed.
      unused_group_bits     = unused_group_bits | (|(gr.sum >> BLOCK));
      gg                    = gr.g | (gr.p & gg);
      pp                    = gr.p & pp;
    end
    cout = gg | (pp & cin);
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one WIDTH/STAGES-bit slice resolved per stage, slice carry
// registered forward, valid/ready handshake with full backpressure and no drain bubbles.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SLICE_W = WIDTH / STAGES;

  if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_split
    $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*BLOCK");
  end
  if (BLOCK > MAX_BLOCK) begin : g_bad_block
    $error("pipelined_cla_adder: BLOCK exceeds MAX_BLOCK");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             msb_cin;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t             st      [STAGES];
  logic [WIDTH-1:0]   src_a   [STAGES];
  logic [WIDTH-1:0]   src_b   [STAGES];
  logic [WIDTH-1:0]   src_sum [STAGES];
  logic [WIDTH-1:0]   nxt_sum [STAGES];
  logic [SLICE_W-1:0] sl_sum  [STAGES];
  logic [STAGES-1:0]  sl_cin;
  logic [STAGES-1:0]  sl_cout;
  logic [STAGES-1:0]  sl_msb;
  logic [STAGES-1:0]  vin;
  logic [STAGES-1:0]  en;

  // Stage 0 sources come straight from the ports (sub mode inverts B and forces carry-in);
  // later stages read the previous stage record.
  always_comb begin
    src_a[0]   = in_a;
    src_b[0]   = in_sub ? ~in_b : in_b;
    src_sum[0] = '0;
    sl_cin     = '0;
    sl_cin[0]  = in_sub | in_cin;
    vin        = '0;
    vin[0]     = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_a[s]   = st[s-1].a;
      src_b[s]   = st[s-1].b;
      src_sum[s] = st[s-1].sum;
      sl_cin[s]  = st[s-1].carry;
      vin[s]     = st[s-1].valid;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    pipelined_cla_adder_slice #(
      .SLICE_W (SLICE_W),
      .BLOCK   (BLOCK)
    ) u_slice (
      .a       (src_a[s][s*SLICE_W +: SLICE_W]),
      .b       (src_b[s][s*SLICE_W +: SLICE_W]),
      .cin     (sl_cin[s]),
      .sum     (sl_sum[s]),
      .cout    (sl_cout[s]),
      .msb_cin (sl_msb[s])
    );
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      nxt_sum[s]                     = src_sum[s];
      nxt_sum[s][s*SLICE_W +: SLICE_W] = sl_sum[s];
    end
  end

  // A stage may load when it is empty or the stage after it is loading too.
  always_comb begin
    en             = '0;
    en[STAGES-1]   = !st[STAGES-1].valid | out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      en[s] = !st[s].valid | en[s+1];
    end
  end

  // NOTE: data registers are reset as well as valid bits so the outputs read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) st[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (en[s]) begin
          st[s].valid <= vin[s];
          if (vin[s]) begin
            st[s].carry   <= sl_cout[s];
            st[s].msb_cin <= sl_msb[s];
            st[s].sum     <= nxt_sum[s];
            st[s].a       <= src_a[s];
            st[s].b       <= src_b[s];
          end
        end
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = st[STAGES-1].valid;
  assign out_sum   = st[STAGES-1].sum;
  assign out_cout  = st[STAGES-1].carry;
  assign out_ovf   = st[STAGES-1].msb_cin ^ st[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: accepted operands push a reference result,
// an independent monitor pops and compares whenever a result is handed downstream.
module tb_pipelined_cla_adder;

  localparam int WIDTH  = 32;
  localparam int BLOCK  = 4;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_dlv    = 0;
  int   out_mode = 0;
  int   occ;
  logic hold = 1'b0;
  res_t hold_v;
  res_t mon_e;

  pipelined_cla_adder #(
    .WIDTH  (WIDTH),
    .BLOCK  (BLOCK),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic plus the signed-overflow sign rule.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic             c0;
    res_t             r;
    bb     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, otherwise held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        2:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Input side: expected in_ready from occupancy, and push the reference on every accept.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      n_acc = 0;
    end else begin
      occ = n_acc - n_dlv + ((out_valid && out_ready) ? 1 : 0);
      check("in_ready", in_ready, !(occ == STAGES && !out_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
        n_acc++;
      end
    end
  end

  // Output side: stability under stall, then pop and compare on every handoff.
  always @(negedge clk) begin
    if (reset) begin
      n_dlv = 0;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {out_sum, out_cout, out_ovf}, hold_v);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_output: got sum %0h with no result outstanding", out_sum);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum", out_sum, mon_e.sum);
          check("cout", out_cout, mon_e.cout);
          check("ovf", out_ovf, mon_e.ovf);
        end
        n_dlv++;
      end
      hold   = out_valid && !out_ready;
      hold_v = {out_sum, out_cout, out_ovf};
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge with in_valid still high.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    int n;
    n        = 0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("send_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
    int n;
    send(a, b, cin, sub);
    in_valid = 1'b0;
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, STAGES);
    check({name, "_sum"}, out_sum, exp_sum);
    check({name, "_cout"}, out_cout, exp_cout);
    check({name, "_ovf"}, out_ovf, exp_ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pick_op();
    logic [WIDTH-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    if ($urandom_range(7) == 0) return corners[$urandom_range(3)];
    return $urandom;
  endfunction

  initial begin
    int    start_dlv;
    longint t0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, '0);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    directed("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("add_cin", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
    directed("sub_cin_ignored", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Full-rate acceptance with out_ready held high.
    t0 = $time;
    for (int i = 0; i < 8; i++) send(pick_op(), pick_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    check("throughput_cycles", ($time - t0) / 10, 8);
    in_valid = 1'b0;
    drain("throughput");

    // Back-to-back ops against a toggling out_ready.
    out_mode  = 1;
    start_dlv = n_dlv;
    for (int i = 0; i < 16; i++) send(pick_op(), pick_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    in_valid = 1'b0;
    drain("toggle");
    check("toggle_count", n_dlv - start_dlv, 16);

    // Reset with three ops stalled in flight.
    out_mode = 3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(pick_op(), pick_op(), 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_sum", out_sum, '0);
    check("async_rst_cout", out_cout, 1'b0);
    check("async_rst_ovf", out_ovf, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #3;
    reset    = 1'b0;
    out_mode = 0;
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_sum", out_sum, '0);
    check("post_rst_in_ready", in_ready, 1'b1);
    directed("post_rst_op", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);

    // Random traffic with random valid gaps and random backpressure.
    out_mode  = 2;
    start_dlv = n_dlv;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(pick_op(), pick_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    in_valid = 1'b0;
    drain("random");
    check("random_count", n_dlv - start_dlv, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
